// File: rtl/reg_pkg.sv
// reg_pkg: shared register-renaming constants and types.
//   NUM_PHYS_REGS / NUM_ARCH_REGS : physical and architectural register counts
//   TAGW                          : physical tag width
//   FREE_PORTS / ALLOC_PORTS      : retire-side free ports, rename-side alloc ports
//   phys_tag_t                    : physical register tag
package reg_pkg;
  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int TAGW          = $clog2(NUM_PHYS_REGS);
  localparam int FREE_PORTS    = 6;
  localparam int ALLOC_PORTS   = 2;

  typedef logic [TAGW-1:0] phys_tag_t;
endpackage

// File: rtl/frl_compact.sv
// frl_compact: combinational compaction of the free-request ports.
// Valid ports are packed, in ascending port order, into the low slots of
// o_tag; o_count reports how many slots are occupied.
//   i_valid [FREE_PORTS]        : per-port request valid
//   i_tag   [FREE_PORTS][TAGW]  : per-port tag
//   o_count                     : number of valid ports
//   o_tag   [FREE_PORTS][TAGW]  : packed tags, slot 0 = lowest valid port
module frl_compact
  import reg_pkg::*;
#(
  parameter int FREE_PORTS = reg_pkg::FREE_PORTS,
  parameter int TAGW       = reg_pkg::TAGW
) (
  input  logic [FREE_PORTS-1:0]                   i_valid,
  input  logic [FREE_PORTS-1:0][TAGW-1:0]         i_tag,
  output logic [$clog2(FREE_PORTS+1)-1:0]         o_count,
  output logic [FREE_PORTS-1:0][TAGW-1:0]         o_tag
);
  localparam int CW = $clog2(FREE_PORTS+1);

  // w_pos[p] = number of valid ports below p = destination slot of port p
  logic [CW-1:0] w_pos [FREE_PORTS+1];

  assign w_pos[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < FREE_PORTS; gi++) begin : gen_prefix
      assign w_pos[gi+1] = w_pos[gi] + CW'(i_valid[gi]);
    end
  endgenerate

  assign o_count = w_pos[FREE_PORTS];

  always_comb begin
    o_tag = '0;
    for (int p = 0; p < FREE_PORTS; p++) begin
      if (i_valid[p]) begin
        o_tag[w_pos[p]] = i_tag[p];
      end
    end
  end
endmodule

// File: rtl/free_reg_list.sv
// free_reg_list: circular free list of physical register tags.
// Rename takes tags from the head (oldest first, offered with zero latency
// from registered state); retirement returns tags at the tail. A freed tag is
// only offered from the following cycle on.
// Optional feature macro: FREE_REG_LIST_DUP_FILTER_EN -- drops frees of tags
// already in the list (or repeated at a lower port the same cycle).
//   clk, rst             : clock, synchronous active-high reset
//   free_valid/free_tag  : retire-side free requests
//   alloc_valid/alloc_tag: offered tags, slot 0 oldest
//   alloc_take           : rename consumes a prefix of offered slots
//   free_count           : registered occupancy
//   overflow_err         : sticky, a free was dropped for lack of space
module free_reg_list
  import reg_pkg::*;
#(
  parameter int NUM_PHYS_REGS = reg_pkg::NUM_PHYS_REGS,
  parameter int NUM_ARCH_REGS = reg_pkg::NUM_ARCH_REGS,
  parameter int FREE_PORTS    = reg_pkg::FREE_PORTS,
  parameter int ALLOC_PORTS   = reg_pkg::ALLOC_PORTS,
  localparam int TAGW         = $clog2(NUM_PHYS_REGS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FREE_PORTS-1:0]            free_valid,
  input  logic [FREE_PORTS-1:0][TAGW-1:0]  free_tag,
  output logic [ALLOC_PORTS-1:0]           alloc_valid,
  output logic [ALLOC_PORTS-1:0][TAGW-1:0] alloc_tag,
  input  logic [ALLOC_PORTS-1:0]           alloc_take,
  output logic [TAGW:0]                    free_count,
  output logic                             overflow_err
);
  localparam int CNTW      = TAGW + 1;
  localparam int FCW       = $clog2(FREE_PORTS+1);
  localparam int ACW       = $clog2(ALLOC_PORTS+1);
  localparam int INIT_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS;

  logic [TAGW-1:0] r_mem [NUM_PHYS_REGS];
  logic [TAGW-1:0] r_head;
  logic [TAGW-1:0] r_tail;
  logic [CNTW-1:0] r_count;
  logic            r_overflow;

  logic                             w_take_ok;
  logic                             w_prev_take;
  logic [ACW-1:0]                   w_n_pop;
  logic [FREE_PORTS-1:0]            w_fvalid;
  logic [FCW-1:0]                   w_push_req;
  logic [FREE_PORTS-1:0][TAGW-1:0]  w_push_tag;
  logic [CNTW-1:0]                  w_after_pop;
  logic [CNTW-1:0]                  w_space;
  logic [CNTW-1:0]                  w_n_push;
  logic                             w_drop;

  // Offer slots straight from registered state.
  genvar gi;
  generate
    for (gi = 0; gi < ALLOC_PORTS; gi++) begin : gen_offer
      assign alloc_valid[gi] = (r_count > CNTW'(gi));
      assign alloc_tag[gi]   = r_mem[r_head + TAGW'(gi)];
    end
  endgenerate

  // A take pattern is honoured only if it is a contiguous run from slot 0
  // and every taken slot is valid; any other pattern pops nothing.
  always_comb begin
    w_take_ok   = 1'b1;
    w_prev_take = 1'b1;
    w_n_pop     = '0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      if (alloc_take[i]) begin
        if (!w_prev_take || !alloc_valid[i]) begin
          w_take_ok = 1'b0;
        end
        w_n_pop = w_n_pop + ACW'(1);
      end
      w_prev_take = alloc_take[i];
    end
    if (!w_take_ok) begin
      w_n_pop = '0;
    end
  end

`ifdef FREE_REG_LIST_DUP_FILTER_EN
  logic [NUM_PHYS_REGS-1:0] r_inlist;

  // In-list test uses pre-cycle state, so a tag popped this cycle still
  // counts as present and its free is dropped.
  always_comb begin
    w_fvalid = '0;
    for (int p = 0; p < FREE_PORTS; p++) begin
      w_fvalid[p] = free_valid[p] && !r_inlist[free_tag[p]];
      for (int q = 0; q < p; q++) begin
        if (free_valid[q] && (free_tag[q] == free_tag[p])) begin
          w_fvalid[p] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_PHYS_REGS; t++) begin
        r_inlist[t] <= (t >= NUM_ARCH_REGS);
      end
    end else begin
      for (int i = 0; i < ALLOC_PORTS; i++) begin
        if (ACW'(i) < w_n_pop) begin
          r_inlist[alloc_tag[i]] <= 1'b0;
        end
      end
      for (int k = 0; k < FREE_PORTS; k++) begin
        if (CNTW'(k) < w_n_push) begin
          r_inlist[w_push_tag[k]] <= 1'b1;
        end
      end
    end
  end
`else
  assign w_fvalid = free_valid;
`endif

  frl_compact #(
    .FREE_PORTS (FREE_PORTS),
    .TAGW       (TAGW)
  ) u_compact (
    .i_valid (w_fvalid),
    .i_tag   (free_tag),
    .o_count (w_push_req),
    .o_tag   (w_push_tag)
  );

  // Space is measured after this cycle's pops; compacted pushes beyond it
  // are dropped and flagged.
  assign w_after_pop = r_count - CNTW'(w_n_pop);
  assign w_space     = CNTW'(NUM_PHYS_REGS) - w_after_pop;
  assign w_drop      = (CNTW'(w_push_req) > w_space);
  assign w_n_push    = w_drop ? w_space : CNTW'(w_push_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_PHYS_REGS; j++) begin
        r_mem[j] <= (j < INIT_FREE) ? TAGW'(NUM_ARCH_REGS + j) : '0;
      end
      r_head     <= '0;
      r_tail     <= TAGW'(INIT_FREE);
      r_count    <= CNTW'(INIT_FREE);
      r_overflow <= 1'b0;
    end else begin
      for (int k = 0; k < FREE_PORTS; k++) begin
        if (CNTW'(k) < w_n_push) begin
          r_mem[r_tail + TAGW'(k)] <= w_push_tag[k];
        end
      end
      r_head  <= r_head + TAGW'(w_n_pop);
      r_tail  <= r_tail + TAGW'(w_n_push);
      r_count <= w_after_pop + w_n_push;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign free_count   = r_count;
  assign overflow_err = r_overflow;
endmodule

// File: tb/tb_free_reg_list.sv
// tb_free_reg_list: self-checking bench for free_reg_list (64 phys, 32 arch).
// A queue-based reference model holds the free tags in offer order.
// Honours FREE_REG_LIST_DUP_FILTER_EN when defined.
module tb_free_reg_list;
  import reg_pkg::*;

  localparam int NP = 64;
  localparam int NA = 32;
  localparam int FP = 6;
  localparam int AP = 2;
  localparam int TW = 6;

`ifdef FREE_REG_LIST_DUP_FILTER_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [FP-1:0]            free_valid;
  logic [FP-1:0][TW-1:0]    free_tag;
  logic [AP-1:0]            alloc_valid;
  logic [AP-1:0][TW-1:0]    alloc_tag;
  logic [AP-1:0]            alloc_take;
  logic [TW:0]              free_count;
  logic                     overflow_err;

  always #5 clk = ~clk;

  free_reg_list #(
    .NUM_PHYS_REGS (NP),
    .NUM_ARCH_REGS (NA),
    .FREE_PORTS    (FP),
    .ALLOC_PORTS   (AP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .free_valid   (free_valid),
    .free_tag     (free_tag),
    .alloc_valid  (alloc_valid),
    .alloc_tag    (alloc_tag),
    .alloc_take   (alloc_take),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int txn      = 0;
  int mq[$];
  bit m_ovf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (txn %0d)", tag, got, exp, txn);
    end
  endtask

  function automatic bit has(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int j = 0; j < NP - NA; j++) mq.push_back(NA + j);
    m_ovf = 1'b0;
  endtask

  // Pops: only a contiguous take run from slot 0 whose slots all hold tags.
  // Pushes: valid ports in port order while the list has room.
  task automatic model_step(input logic [AP-1:0] take, input logic [FP-1:0] fv,
                            input logic [FP-1:0][TW-1:0] tags);
    int snap[$];
    int seen[$];
    int n;
    snap = mq;
    n = 0;
    if (take == 2'b01 && mq.size() >= 1) n = 1;
    if (take == 2'b11 && mq.size() >= 2) n = 2;
    repeat (n) void'(mq.pop_front());
    for (int p = 0; p < FP; p++) begin
      if (fv[p]) begin
        int t;
        bit skip;
        t = int'(tags[p]);
        skip = DUP && (has(snap, t) || has(seen, t));
        seen.push_back(t);
        if (!skip) begin
          if (mq.size() < NP) mq.push_back(t);
          else m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic check_state();
    check_val("free_count", 32'(free_count), mq.size());
    check_val("overflow_err", 32'(overflow_err), 32'(m_ovf));
    for (int i = 0; i < AP; i++) begin
      check_val($sformatf("alloc_valid%0d", i), 32'(alloc_valid[i]), 32'(mq.size() > i));
      if (mq.size() > i) check_val($sformatf("alloc_tag%0d", i), 32'(alloc_tag[i]), mq[i]);
    end
  endtask

  // One transaction: drive at negedge, model at posedge, check at next negedge.
  task automatic cycle(input bit r, input logic [AP-1:0] take, input logic [FP-1:0] fv,
                       input logic [FP-1:0][TW-1:0] tags);
    rst        = r;
    alloc_take = take;
    free_valid = fv;
    free_tag   = tags;
    @(posedge clk);
    if (r) model_reset();
    else   model_step(take, fv, tags);
    txn++;
    $display("txn %0d rst=%0b take=%b fv=%b model_count=%0d", txn, r, take, fv, mq.size());
    @(negedge clk);
    check_state();
  endtask

  task automatic do_reset();
    cycle(1'b1, 2'b11, 6'h3f, '1);
  endtask

  logic [FP-1:0][TW-1:0] t;
  logic [FP-1:0]         fv;

  initial begin
    rst = 1'b1;
    alloc_take = '0;
    free_valid = '0;
    free_tag   = '0;
    @(posedge clk);
    @(negedge clk);

    // Reset state, with active inputs held during reset.
    do_reset();
    check_val("rst_count", 32'(free_count), 32);
    check_val("rst_valid", 32'(alloc_valid), 3);
    check_val("rst_tag0", 32'(alloc_tag[0]), 32);
    check_val("rst_tag1", 32'(alloc_tag[1]), 33);
    check_val("rst_ovf", 32'(overflow_err), 0);

    // Drain completely, then an illegal take at empty.
    repeat (16) cycle(1'b0, 2'b11, '0, '0);
    check_val("drain_count", 32'(free_count), 0);
    check_val("drain_valid", 32'(alloc_valid), 0);
    cycle(1'b0, 2'b10, '0, '0);
    check_val("empty_take10_count", 32'(free_count), 0);
    check_val("empty_take10_valid", 32'(alloc_valid), 0);

    // Push on ports 1 and 4 alongside a single pop.
    do_reset();
    repeat (15) cycle(1'b0, 2'b11, '0, '0);
    cycle(1'b0, 2'b01, '0, '0);
    check_val("pre_push_count", 32'(free_count), 1);
    check_val("pre_push_tag0", 32'(alloc_tag[0]), 63);
    t = '0; t[1] = 6'd40; t[4] = 6'd7;
    cycle(1'b0, 2'b01, 6'b010010, t);
    check_val("pushpop_count", 32'(free_count), 2);
    check_val("pushpop_tag0", 32'(alloc_tag[0]), 40);
    check_val("pushpop_tag1", 32'(alloc_tag[1]), 7);

    // Wrap: drain, push 40 tags across index 63->0, pop them back in order.
    do_reset();
    repeat (16) cycle(1'b0, 2'b11, '0, '0);
    for (int c = 0; c < 7; c++) begin
      fv = (c < 6) ? 6'h3f : 6'h0f;
      for (int p = 0; p < FP; p++) t[p] = TW'(c * 6 + p);
      cycle(1'b0, 2'b00, fv, t);
    end
    check_val("wrap_count", 32'(free_count), 40);
    for (int i = 0; i < 20; i++) begin
      check_val("wrap_tag0", 32'(alloc_tag[0]), 2 * i);
      check_val("wrap_tag1", 32'(alloc_tag[1]), 2 * i + 1);
      cycle(1'b0, 2'b11, '0, '0);
    end
    check_val("wrap_end_count", 32'(free_count), 0);

    // Overflow: fill to 62, then offer 6 frees.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      for (int p = 0; p < FP; p++) t[p] = TW'(c * 6 + p);
      cycle(1'b0, 2'b00, 6'h3f, t);
    end
    check_val("ovf_pre_count", 32'(free_count), 62);
    t[0] = 6'd30; t[1] = 6'd31; t[2] = 6'd0; t[3] = 6'd1; t[4] = 6'd2; t[5] = 6'd3;
    cycle(1'b0, 2'b00, 6'h3f, t);
    check_val("ovf_count", 32'(free_count), 64);
    check_val("ovf_flag", 32'(overflow_err), DUP ? 0 : 1);
    repeat (3) cycle(1'b0, 2'b11, '0, '0);
    check_val("ovf_sticky", 32'(overflow_err), DUP ? 0 : 1);
    do_reset();
    check_val("ovf_cleared", 32'(overflow_err), 0);

    // Free of a tag already on the list.
    t = '0; t[0] = 6'd40;
    cycle(1'b0, 2'b00, 6'b000001, t);
    check_val("dup_count", 32'(free_count), DUP ? 32 : 33);

    // Randomized traffic with occasional mid-run resets.
    for (int n = 0; n < 600; n++) begin
      bit r;
      logic [AP-1:0] tk;
      r  = ($urandom_range(0, 99) == 0);
      tk = AP'($urandom);
      for (int p = 0; p < FP; p++) begin
        fv[p] = ($urandom_range(0, 3) == 0);
        t[p]  = TW'($urandom_range(0, NP - 1));
      end
      cycle(r, tk, fv, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
